parking_slot_store: RTL and testbench
=====================================

Name: parking_slot_store

Overview:
- Storage end of the parking entry/exit handshake.
- Consumes single-cycle write_enable (car entered) and read_enable (car leaves) pulses from the parking control FSM.
- Holds parked car IDs in arrival order in a circular buffer.
- Returns is_empty/is_full back to the FSM; also reports occupancy and protocol-violation flags.

Parameters:
- DEPTH, 8, number of parking slots (2..255, any integer, not restricted to powers of two).
- ID_W, 8, width of the car identifier.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- write_enable  in  1  store car_id_in into next free slot.
- read_enable  in  1  release oldest parked car.
- car_id_in  in  ID_W  ID of entering car, sampled when write_enable=1.
- car_id_out  out  ID_W  ID of released car, registered.
- out_valid  out  1  one-cycle strobe: car_id_out holds a valid released ID.
- is_empty  out  1  occupancy==0.
- is_full  out  1  occupancy==DEPTH.
- occupancy  out  CNT_W  number of parked cars.
- overflow_err  out  1  one-cycle pulse: write refused.
- underflow_err  out  1  one-cycle pulse: read refused.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - wr_ptr=0, rd_ptr=0, occupancy=0.
  - is_empty=1, is_full=0.
  - car_id_out=0, out_valid=0, overflow_err=0, underflow_err=0.
  - Slot array contents need not be cleared.
- Reset mid-operation discards all parked cars; the first post-reset write lands in slot 0.
- Pointers wrap explicitly: when ptr==DEPTH-1, the next value is 0. Power-of-two masking is not used.
- Write, accepted when !is_full: slot[wr_ptr]<=car_id_in, wr_ptr advances, occupancy+1.
- Read, accepted when !is_empty: car_id_out<=slot[rd_ptr], out_valid=1 in the next cycle, rd_ptr advances, occupancy-1.
- Read latency: exactly one clock from the read_enable edge to out_valid. car_id_out holds its value until the next accepted read.
- Simultaneous write and read:
  - Neither empty nor full: both accepted, occupancy unchanged. The read returns the oldest entry, not the incoming ID.
  - Full: read accepted; write refused, overflow_err pulses, occupancy becomes DEPTH-1.
  - Empty: write accepted; read refused, underflow_err pulses, out_valid stays 0, occupancy becomes 1.
- Write alone when full: no state change, overflow_err pulses for one cycle.
- Read alone when empty: no state change, underflow_err pulses for one cycle.
- is_empty, is_full and occupancy are registered and update in the same edge as the pointers. The FSM sees new status one cycle after its enable pulse. This is sufficient because the FSM spends at least two cycles per transaction.
- No internal FSM beyond the pointer/count registers. Counter arithmetic is CNT_W unsigned and never wraps, because refusal rules prevent it.

Optional Feature:
- Macro PARK_DWELL_EN.
- When defined:
  - Adds a free-running 16-bit cycle counter, reset to 0, which wraps.
  - Adds a per-slot 16-bit entry timestamp captured on each accepted write.
  - Adds output dwell_out[15:0], registered alongside car_id_out = (counter - stamp) mod 2^16, updated only on accepted reads.
  - dwell_out resets to 0.
- When undefined: no counter, no timestamp storage, no dwell_out port; all other behaviour is identical.

Decomposition:
- Shared package parking_pkg:
  - PARK_DEPTH and PARK_ID_W default constants.
  - car_id_t typedef.
  - Function cnt_width(depth).
  - The control FSM state encoding (IDLE/ENTRY/EXIT) so both ends share one definition.
- One natural sub-module: park_wrap_ptr, a parameterised pointer with inc enable, explicit wrap at DEPTH-1 and async active-low clear. Instantiate it twice (wr/rd).

Test Plan:
- Reset then idle, DEPTH=8: is_empty=1, is_full=0, occupancy=0, no error pulses.
- Write IDs 0x11,0x22,0x33, then 3 reads: car_id_out sequence 0x11,0x22,0x33, each with out_valid one cycle after read_enable; is_empty=1 afterwards.
- Fill 8 IDs, then a 9th write 0xAA: is_full=1, overflow_err pulses once, occupancy stays 8; the next 8 reads never return 0xAA.
- Read with empty store, then simultaneous write 0x5C + read on empty: first gives underflow_err, no out_valid; second gives occupancy=1 and underflow_err; the next read returns 0x5C.
- Wrap: 6 writes, 6 reads, 6 writes, 6 reads with distinct IDs: FIFO order is preserved across the slot 7->0 wrap. Repeat with DEPTH=5.
- Reset asserted with occupancy=4: immediately is_empty=1 and occupancy=0. After release, write 0x77 then read returns 0x77.
- PARK_DWELL_EN: write, wait 20 cycles, read: dwell_out=21 (write-edge to read-edge count).

Source files
------------

// File: rtl/parking_pkg.sv
// Shared constants, types and control-FSM state encoding for the parking
// entry/exit handshake (used by the slot store and the control FSM).
package parking_pkg;

  localparam int PARK_DEPTH = 8;
  localparam int PARK_ID_W  = 8;

  typedef logic [PARK_ID_W-1:0] car_id_t;

  // Owned here so the control FSM and the store agree on one encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    EXIT  = 2'd2
  } park_ctrl_state_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/park_wrap_ptr.sv
// Slot pointer with increment enable and explicit wrap from DEPTH-1 to 0, so
// any DEPTH works, not only powers of two.
module park_wrap_ptr
  import parking_pkg::*;
#(
  parameter int DEPTH = PARK_DEPTH,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/parking_slot_store.sv
// Circular buffer of parked car IDs in arrival order, with registered status.
// Define PARK_DWELL_EN to add per-car dwell time reporting on dwell_out.
module parking_slot_store
  import parking_pkg::*;
#(
  parameter int DEPTH = PARK_DEPTH,
  parameter int ID_W  = PARK_ID_W,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             write_enable,
  input  logic             read_enable,
  input  logic [ID_W-1:0]  car_id_in,
  output logic [ID_W-1:0]  car_id_out,
  output logic             out_valid,
  output logic             is_empty,
  output logic             is_full,
  output logic [CNT_W-1:0] occupancy,
  output logic             overflow_err,
  output logic             underflow_err
`ifdef PARK_DWELL_EN
  ,
  output logic [15:0]      dwell_out
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ID_W-1:0]  slot_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic [CNT_W-1:0] occ_q, occ_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic [ID_W-1:0]  id_out_q, id_out_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic wr_accept;
  logic rd_accept;

  // Refusals are decided from the registered status, which is what the FSM sees.
  assign wr_accept = write_enable && !full_q;
  assign rd_accept = read_enable && !empty_q;

  park_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (wr_accept),
    .ptr   (wr_ptr)
  );

  park_wrap_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (rd_accept),
    .ptr   (rd_ptr)
  );

  always_comb begin
    occ_d    = occ_q;
    id_out_d = id_out_q;
    case ({wr_accept, rd_accept})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    if (rd_accept) begin
      id_out_d = slot_mem[rd_ptr];
    end
    empty_d = (occ_d == '0);
    full_d  = (occ_d == FULL_CNT);
    valid_d = rd_accept;
    ovf_d   = write_enable && full_q;
    unf_d   = read_enable && empty_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q    <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      id_out_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      occ_q    <= occ_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      id_out_q <= id_out_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Slot contents survive reset; the pointers alone define what is parked.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      slot_mem[wr_ptr] <= car_id_in;
    end
  end

  assign car_id_out    = id_out_q;
  assign out_valid     = valid_q;
  assign is_empty      = empty_q;
  assign is_full       = full_q;
  assign occupancy     = occ_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

`ifdef PARK_DWELL_EN
  logic [15:0] cycle_cnt_q, cycle_cnt_d;
  logic [15:0] dwell_q, dwell_d;
  logic [15:0] stamp_mem [DEPTH];

  // Modulo-2^16 subtraction keeps dwell correct across counter wrap.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q + 16'd1;
    dwell_d     = dwell_q;
    if (rd_accept) begin
      dwell_d = cycle_cnt_q - stamp_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_cnt_q <= '0;
      dwell_q     <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      dwell_q     <= dwell_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      stamp_mem[wr_ptr] <= cycle_cnt_q;
    end
  end

  assign dwell_out = dwell_q;
`endif

endmodule

// File: tb/tb_parking_slot_store.sv
// Directed bench for parking_slot_store at DEPTH=8 and DEPTH=5.
module tb_parking_slot_store;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       a_we, a_re, b_we, b_re;
  logic [7:0] a_id_in, b_id_in, a_id_out, b_id_out;
  logic       a_valid, a_empty, a_full, a_ovf, a_unf;
  logic       b_valid, b_empty, b_full, b_ovf, b_unf;
  logic [3:0] a_occ;
  logic [2:0] b_occ;
`ifdef PARK_DWELL_EN
  logic [15:0] a_dwell, b_dwell;
`endif

  parking_slot_store #(.DEPTH(8), .ID_W(8)) dut_a (
    .clk           (clk),
    .reset_n       (reset_n),
    .write_enable  (a_we),
    .read_enable   (a_re),
    .car_id_in     (a_id_in),
    .car_id_out    (a_id_out),
    .out_valid     (a_valid),
    .is_empty      (a_empty),
    .is_full       (a_full),
    .occupancy     (a_occ),
    .overflow_err  (a_ovf),
    .underflow_err (a_unf)
`ifdef PARK_DWELL_EN
    ,
    .dwell_out     (a_dwell)
`endif
  );

  parking_slot_store #(.DEPTH(5), .ID_W(8)) dut_b (
    .clk           (clk),
    .reset_n       (reset_n),
    .write_enable  (b_we),
    .read_enable   (b_re),
    .car_id_in     (b_id_in),
    .car_id_out    (b_id_out),
    .out_valid     (b_valid),
    .is_empty      (b_empty),
    .is_full       (b_full),
    .occupancy     (b_occ),
    .overflow_err  (b_ovf),
    .underflow_err (b_unf)
`ifdef PARK_DWELL_EN
    ,
    .dwell_out     (b_dwell)
`endif
  );

  int   checks   = 0;
  int   failures = 0;
  logic sel      = 1'b0;

  logic [7:0] obs_id;
  logic       obs_valid, obs_empty, obs_full, obs_ovf, obs_unf;
  logic [3:0] obs_occ;
  assign obs_id    = sel ? b_id_out : a_id_out;
  assign obs_valid = sel ? b_valid  : a_valid;
  assign obs_empty = sel ? b_empty  : a_empty;
  assign obs_full  = sel ? b_full   : a_full;
  assign obs_ovf   = sel ? b_ovf    : a_ovf;
  assign obs_unf   = sel ? b_unf    : a_unf;
  assign obs_occ   = sel ? {1'b0, b_occ} : a_occ;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one clock of enables to the selected DUT; outputs are sampled 1 after the edge.
  task automatic do_cycle(input logic we, input logic re, input logic [7:0] id);
    if (sel) begin
      b_we = we; b_re = re; b_id_in = id;
    end else begin
      a_we = we; a_re = re; a_id_in = id;
    end
    @(posedge clk);
    #1;
    a_we = 1'b0; a_re = 1'b0; b_we = 1'b0; b_re = 1'b0;
    $display("tx dut=%0d we=%0b re=%0b id=%02h -> valid=%0b out=%02h occ=%0d empty=%0b full=%0b ovf=%0b unf=%0b",
             sel, we, re, id, obs_valid, obs_id, obs_occ, obs_empty, obs_full, obs_ovf, obs_unf);
  endtask

  task automatic write_id(input logic [7:0] id);
    do_cycle(1'b1, 1'b0, id);
  endtask

  task automatic read_expect(input string tag, input logic [7:0] id);
    do_cycle(1'b0, 1'b1, 8'h00);
    check_value({tag, "_valid"}, 32'(obs_valid), 32'd1);
    check_value({tag, "_id"}, 32'(obs_id), 32'(id));
  endtask

  initial begin
    reset_n = 1'b0;
    a_we = 1'b0; a_re = 1'b0; a_id_in = '0;
    b_we = 1'b0; b_re = 1'b0; b_id_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_empty", 32'(obs_empty), 32'd1);
    check_value("rst_full", 32'(obs_full), 32'd0);
    check_value("rst_occ", 32'(obs_occ), 32'd0);
    check_value("rst_id_out", 32'(obs_id), 32'd0);
    check_value("rst_valid", 32'(obs_valid), 32'd0);
    reset_n = 1'b1;
    do_cycle(1'b0, 1'b0, 8'h00);
    check_value("idle_empty", 32'(obs_empty), 32'd1);
    check_value("idle_ovf", 32'(obs_ovf), 32'd0);
    check_value("idle_unf", 32'(obs_unf), 32'd0);
    check_value("b_rst_empty", 32'(b_empty), 32'd1);

    // Basic FIFO order
    write_id(8'h11); write_id(8'h22); write_id(8'h33);
    check_value("basic_occ", 32'(obs_occ), 32'd3);
    check_value("basic_valid_pre", 32'(obs_valid), 32'd0);
    read_expect("basic_rd0", 8'h11);
    read_expect("basic_rd1", 8'h22);
    read_expect("basic_rd2", 8'h33);
    check_value("basic_empty", 32'(obs_empty), 32'd1);
    do_cycle(1'b0, 1'b0, 8'h00);
    check_value("hold_valid", 32'(obs_valid), 32'd0);
    check_value("hold_id", 32'(obs_id), 32'h33);

    // Fill, then overflow attempt
    for (int i = 0; i < 8; i++) write_id(8'(8'h80 + i));
    check_value("fill_full", 32'(obs_full), 32'd1);
    check_value("fill_occ", 32'(obs_occ), 32'd8);
    do_cycle(1'b1, 1'b0, 8'hAA);
    check_value("ovf_pulse", 32'(obs_ovf), 32'd1);
    check_value("ovf_occ", 32'(obs_occ), 32'd8);
    check_value("ovf_full", 32'(obs_full), 32'd1);
    do_cycle(1'b0, 1'b0, 8'h00);
    check_value("ovf_clear", 32'(obs_ovf), 32'd0);
    for (int i = 0; i < 8; i++) read_expect("drain", 8'(8'h80 + i));
    check_value("drain_empty", 32'(obs_empty), 32'd1);

    // Underflow, alone and with a simultaneous write
    do_cycle(1'b0, 1'b1, 8'h00);
    check_value("unf_pulse", 32'(obs_unf), 32'd1);
    check_value("unf_valid", 32'(obs_valid), 32'd0);
    check_value("unf_occ", 32'(obs_occ), 32'd0);
    do_cycle(1'b1, 1'b1, 8'h5C);
    check_value("unf_wr_pulse", 32'(obs_unf), 32'd1);
    check_value("unf_wr_valid", 32'(obs_valid), 32'd0);
    check_value("unf_wr_occ", 32'(obs_occ), 32'd1);
    check_value("unf_wr_empty", 32'(obs_empty), 32'd0);
    read_expect("unf_rd", 8'h5C);

    // Simultaneous write+read while full
    for (int i = 0; i < 8; i++) write_id(8'(8'h40 + i));
    do_cycle(1'b1, 1'b1, 8'h99);
    check_value("fullrw_ovf", 32'(obs_ovf), 32'd1);
    check_value("fullrw_valid", 32'(obs_valid), 32'd1);
    check_value("fullrw_id", 32'(obs_id), 32'h40);
    check_value("fullrw_occ", 32'(obs_occ), 32'd7);
    check_value("fullrw_full", 32'(obs_full), 32'd0);
    for (int i = 1; i < 8; i++) read_expect("fullrw_drain", 8'(8'h40 + i));
    check_value("fullrw_empty", 32'(obs_empty), 32'd1);

    // Simultaneous write+read mid-occupancy returns the oldest entry
    write_id(8'h61); write_id(8'h62);
    do_cycle(1'b1, 1'b1, 8'h63);
    check_value("midrw_id", 32'(obs_id), 32'h61);
    check_value("midrw_occ", 32'(obs_occ), 32'd2);
    check_value("midrw_ovf", 32'(obs_ovf), 32'd0);
    read_expect("midrw_rd0", 8'h62);
    read_expect("midrw_rd1", 8'h63);

    // Wrap at DEPTH=8 (write pointer currently sits at slot 7)
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 6; i++) write_id(8'(8'hC0 + r * 6 + i));
      for (int i = 0; i < 6; i++) read_expect("wrap8", 8'(8'hC0 + r * 6 + i));
    end
    check_value("wrap8_empty", 32'(obs_empty), 32'd1);

    // Wrap at DEPTH=5
    sel = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 4; i++) write_id(8'(8'hD0 + r * 4 + i));
      check_value("wrap5_occ", 32'(obs_occ), 32'd4);
      for (int i = 0; i < 4; i++) read_expect("wrap5", 8'(8'hD0 + r * 4 + i));
    end
    for (int i = 0; i < 5; i++) write_id(8'(8'hE0 + i));
    check_value("wrap5_full", 32'(obs_full), 32'd1);
    for (int i = 0; i < 5; i++) read_expect("wrap5_fill", 8'(8'hE0 + i));
    sel = 1'b0;

    // Asynchronous reset mid-operation
    for (int i = 0; i < 4; i++) write_id(8'(8'h50 + i));
    check_value("mid_occ4", 32'(obs_occ), 32'd4);
    reset_n = 1'b0;
    #2;
    check_value("mid_rst_occ", 32'(obs_occ), 32'd0);
    check_value("mid_rst_empty", 32'(obs_empty), 32'd1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    write_id(8'h77);
    check_value("post_rst_occ", 32'(obs_occ), 32'd1);
    read_expect("post_rst_rd", 8'h77);

`ifdef PARK_DWELL_EN
    write_id(8'h3D);
    repeat (20) do_cycle(1'b0, 1'b0, 8'h00);
    read_expect("dwell_rd", 8'h3D);
    check_value("dwell_val", 32'(a_dwell), 32'd21);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
